// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned REG_ZERO  = 0;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write tracker: flush beats issue-set, which beats write-back clear.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = addr_width(NREGS),
    localparam int unsigned CW   = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic              flush_i,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREGS-1:0]  busy_vec_o,
    output logic [CW-1:0]     busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        busy_d = busy_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        // A new producer supersedes a write-back of the old one in the same cycle.
        if (iss_en_i && (iss_rd_i != AW'(REG_ZERO))) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        cnt_d = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with x0 hardwired, highest-port-wins writes, optional same-cycle bypass.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_vec_o,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Ascending port order lets the highest enabled port win an address conflict.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] != AW'(REG_ZERO))) begin
                regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   raddr;
        logic [XLEN-1:0] rdata;
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            raddr = rd_addr_i[i*AW +: AW];
            rdata = regs_q[raddr];
            if (BYPASS) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == raddr)) begin
                        rdata = wr_data_i[j*XLEN +: XLEN];
                    end
                end
            end
            if (raddr == AW'(REG_ZERO)) begin
                rdata = '0;
            end
            rd_data_o[i*XLEN +: XLEN] = rdata;
            // Busy comes from registered state only; the hazard unit does its own forwarding.
            rd_busy_o[i] = busy_vec_o[raddr];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .iss_en_i   (iss_en_i),
        .iss_rd_i   (iss_rd_i),
        .flush_i    (flush_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .busy_vec_o (busy_vec_o),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined core, with write-through bypass and a per-register pending-write scoreboard. It replaces the single-write, negedge-write register file; all state now updates on the rising edge, and same-cycle read-after-write is handled by internal forwarding. The ID stage reads operands and busy flags. Issue marks destination registers pending. WB ports write results and clear pending flags.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rd_addr  in  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data
rd_busy  out  NRD  1 = read register has a pending write
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  packed write addresses
wr_data  in  NWR*XLEN  packed write data
iss_en  in  1  instruction issued with a destination register
iss_rd  in  AW  destination register to mark pending
flush  in  1  clears all pending flags (pipeline squash)
busy_vec  out  NREGS  scoreboard state, bit r = register r pending
busy_cnt  out  AW+1  number of set bits in busy_vec (registered)

Behaviour:
- Reset (async): all registers 0; busy_vec 0; busy_cnt 0. rd_data and rd_busy are combinational, so they read 0 after reset.
- Register 0 is hardwired: reads return 0; writes to it are ignored; it is never marked busy; rd_busy is 0 for it.
- Writes are synchronous on posedge clk when wr_en[j]=1 and wr_addr[j]!=0.
- Write conflict: if two enabled ports target the same address, the highest index j wins. The lower port's write is dropped silently, and no error is raised.
- Reads are combinational with zero latency. With BYPASS=1, if any enabled write port targets rd_addr[i]!=0 in the same cycle, rd_data[i] is the winning port's wr_data; otherwise it is the array value. With BYPASS=0, rd_data is the array value only, and the new value is visible the cycle after the write.
- Scoreboard, evaluated per register r at posedge in this priority order:
  1. flush=1: all bits clear. An iss_en in the same cycle is ignored.
  2. iss_en=1 and iss_rd==r with r!=0: bit set. Set wins over a same-cycle clear of the same register, because the new producer supersedes the old one.
  3. Any wr_en[j]=1 with wr_addr[j]==r: bit clears.
- rd_busy[i] = busy_vec[rd_addr[i]], taken from registered state. It is not bypassed: a write in the current cycle does not deassert rd_busy until the next cycle. The hazard unit combines rd_busy with its own forwarding.
- A write to a register that is not busy is legal: data is written and the flag stays 0.
- busy_cnt is updated together with busy_vec and always equals popcount(busy_vec) in the same cycle. Its maximum is NREGS-1.
- Reset asserted mid-operation immediately clears the array and the scoreboard, whatever writes or issues are in flight.

Decomposition:
- Shared package regfile_pkg holds the default XLEN/NREGS constants, the AW derivation function, and the x0 address constant (REG_ZERO).
- One sub-module, rf_scoreboard: busy_vec, busy_cnt, and the set/clear/flush priority.
- The top level holds the storage array, the write arbitration, and the read/bypass muxing.

Test Plan:
1. Reset: assert rst mid-cycle. All rd_data=0, busy_vec=0, busy_cnt=0 immediately, before the next edge.
2. Bypass: write x5=0xDEADBEEF on port 0 while rd_addr[0]=5. With BYPASS=1, rd_data[0]=0xDEADBEEF in the same cycle. With BYPASS=0, rd_data[0]=0 in that cycle and 0xDEADBEEF in the next.
3. Write conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle. The next cycle reads x7=0x22.
4. x0: write x0=0xFFFFFFFF and issue iss_rd=0. Reads of x0 return 0, busy_vec[0]=0, busy_cnt unchanged.
5. Scoreboard: issue x3, then write x3 two cycles later. busy_vec[3] and rd_busy are 1 for 2 cycles, then 0, with busy_cnt going 1 then 0. Issue x3 and write x3 in the same cycle: busy_vec[3] remains 1.
6. Flush: issue x1, x2, and x4 (busy_cnt=3), then flush with iss_en=1, iss_rd=6. The next cycle shows busy_vec=0 and busy_cnt=0.
